// File: rtl/rpsc_fault_qualifier.sv
// Input conditioning for the RPSC card-12 fault latches: 2-flop synchronisers,
// asymmetric on/off persistence filters per channel and a first-fault record.
module rpsc_fault_qualifier #(
  parameter int ON_CYCLES  = 16,
  parameter int OFF_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] raw_in,
  input  logic       ff_ack,
  output logic [7:0] qual_out,
  output logic [7:0] rise_pulse,
  output logic [2:0] first_fault_id,
  output logic       first_fault_valid
);

  // Terminal counts; the counter never runs past these, so it cannot wrap.
  localparam logic [15:0] ON_TC  = 16'(ON_CYCLES - 1);
  localparam logic [15:0] OFF_TC = 16'(OFF_CYCLES - 1);

  logic [7:0]  r_s1;
  logic [7:0]  r_sync;
  logic [7:0]  r_q;
  logic [7:0]  r_rise;
  logic [15:0] r_cnt [8];
  logic [2:0]  r_ffid;
  logic        r_ffv;

  logic [15:0] w_cnt_nxt [8];
  logic [7:0]  w_q_nxt;
  logic [7:0]  w_set;
  logic [2:0]  w_ffid_nxt;
  logic        w_ffv_keep;
  logic        w_ffv_nxt;

  always_comb begin
    w_q_nxt = r_q;
    w_set   = 8'd0;
    for (int i = 0; i < 8; i++) begin
      w_cnt_nxt[i] = 16'd0;
      if (!r_q[i]) begin
        if (r_sync[i]) begin
          if (r_cnt[i] == ON_TC) begin
            w_q_nxt[i] = 1'b1;
            w_set[i]   = 1'b1;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] + 16'd1;
          end
        end
      end else begin
        if (!r_sync[i]) begin
          if (r_cnt[i] == OFF_TC) begin
            w_q_nxt[i] = 1'b0;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] + 16'd1;
          end
        end
      end
    end
  end

  // Ack is applied first, so a rise on the ack edge is captured into a fresh record.
  always_comb begin
    w_ffv_keep = r_ffv & ~ff_ack;
    w_ffv_nxt  = w_ffv_keep;
    w_ffid_nxt = r_ffid;
    if (!w_ffv_keep && (w_set != 8'd0)) begin
      w_ffv_nxt = 1'b1;
      for (int i = 7; i >= 0; i--) begin
        if (w_set[i]) begin
          w_ffid_nxt = 3'(i);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1   <= 8'd0;
      r_sync <= 8'd0;
      r_q    <= 8'd0;
      r_rise <= 8'd0;
      r_ffid <= 3'd0;
      r_ffv  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_cnt[i] <= 16'd0;
      end
    end else begin
      r_s1   <= raw_in;
      r_sync <= r_s1;
      r_q    <= w_q_nxt;
      r_rise <= w_set;
      r_ffid <= w_ffid_nxt;
      r_ffv  <= w_ffv_nxt;
      for (int i = 0; i < 8; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  assign qual_out          = r_q;
  assign rise_pulse        = r_rise;
  assign first_fault_id    = r_ffid;
  assign first_fault_valid = r_ffv;

endmodule

// File: tb/tb_rpsc_fault_qualifier.sv
// Bench for rpsc_fault_qualifier: directed test-plan phases plus random traffic,
// checked every cycle against a run-length reference model via a scoreboard queue.
module tb_rpsc_fault_qualifier;

  localparam int ON  = 16;
  localparam int OFF = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] raw_in;
  logic       ff_ack;
  logic [7:0] qual_out;
  logic [7:0] rise_pulse;
  logic [2:0] first_fault_id;
  logic       first_fault_valid;

  int n_checks = 0;
  int n_fail   = 0;
  int rise2_cnt;

  logic [19:0] exp_q [$];

  rpsc_fault_qualifier #(.ON_CYCLES(ON), .OFF_CYCLES(OFF)) dut (
    .clk(clk),
    .reset(reset),
    .raw_in(raw_in),
    .ff_ack(ff_ack),
    .qual_out(qual_out),
    .rise_pulse(rise_pulse),
    .first_fault_id(first_fault_id),
    .first_fault_valid(first_fault_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a channel flips once its synchronised input has held the
  // opposite level for a whole threshold-length run.
  initial begin
    int          run [8];
    logic [7:0]  m_last, m_s1, m_sync, m_q, rise;
    logic [2:0]  m_id;
    logic        m_v, keep;
    m_last = 0; m_s1 = 0; m_sync = 0; m_q = 0; m_id = 0; m_v = 0;
    for (int i = 0; i < 8; i++) run[i] = 0;
    forever begin
      @(posedge clk);
      rise = 8'd0;
      if (reset) begin
        m_last = 0; m_s1 = 0; m_sync = 0; m_q = 0; m_id = 0; m_v = 0;
        for (int i = 0; i < 8; i++) run[i] = 0;
      end else begin
        for (int i = 0; i < 8; i++) begin
          if (m_sync[i] == m_last[i]) run[i]++;
          else run[i] = 1;
          m_last[i] = m_sync[i];
          if (!m_q[i] && m_sync[i] && run[i] >= ON) begin
            m_q[i] = 1'b1;
            rise[i] = 1'b1;
          end else if (m_q[i] && !m_sync[i] && run[i] >= OFF) begin
            m_q[i] = 1'b0;
          end
        end
        keep = m_v & ~ff_ack;
        m_v  = keep;
        if (!keep && rise != 8'd0) begin
          m_v = 1'b1;
          for (int j = 7; j >= 0; j--) if (rise[j]) m_id = 3'(j);
        end
        m_sync = m_s1;
        m_s1   = raw_in;
      end
      exp_q.push_back({m_q, rise, m_id, m_v});
    end
  end

  // Monitor: outputs are presented every cycle; compare away from the active edge.
  initial begin
    logic [19:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("qual_out",   qual_out,                   e[19:12]);
        chk("rise_pulse", rise_pulse,                 e[11:4]);
        chk("ff_id",      {5'd0, first_fault_id},     {5'd0, e[3:1]});
        chk("ff_valid",   {7'd0, first_fault_valid},  {7'd0, e[0]});
      end
    end
  end

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      rise2_cnt += int'(rise_pulse[2]);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    step(n);
    reset = 1'b0;
  endtask

  initial begin
    rise2_cnt = 0;
    reset  = 1'b1;
    raw_in = 8'hFF;
    ff_ack = 1'b0;

    // reset values with all inputs high
    step(3);
    chk("rst_qual",  qual_out, 8'h00);
    chk("rst_rise",  rise_pulse, 8'h00);
    chk("rst_ffv",   {7'd0, first_fault_valid}, 8'h00);
    reset = 1'b0;
    step(17);
    chk("pre_on_qual", qual_out, 8'h00);
    step(1);
    chk("on_qual_ff", qual_out, 8'hFF);

    // glitch rejection on channel 2
    raw_in = 8'h00;
    do_reset(2);
    rise2_cnt = 0;
    raw_in = 8'h04;
    step(15);
    raw_in = 8'h00;
    step(1);
    raw_in = 8'h04;
    step(17);
    chk("glitch_hold", qual_out, 8'h00);
    step(8);
    chk("glitch_qual", qual_out, 8'h04);
    chk("glitch_rise_count", 8'(rise2_cnt), 8'd1);

    // off-delay on channel 5
    raw_in = 8'h24;
    step(20);
    chk("off_q5_on", {7'd0, qual_out[5]}, 8'd1);
    raw_in = 8'h04;
    step(63);
    raw_in = 8'h24;
    step(3);
    chk("off_63_hold", {7'd0, qual_out[5]}, 8'd1);
    raw_in = 8'h04;
    step(65);
    chk("off_64_edge65", {7'd0, qual_out[5]}, 8'd1);
    step(1);
    chk("off_64_edge66", {7'd0, qual_out[5]}, 8'd0);

    // first fault with simultaneous rise on 3 and 6
    raw_in = 8'h00;
    do_reset(2);
    raw_in = 8'h48;
    step(20);
    chk("ff_sim_id", {5'd0, first_fault_id}, 8'd3);
    chk("ff_sim_v",  {7'd0, first_fault_valid}, 8'd1);
    raw_in = 8'h49;
    step(20);
    chk("ff_later_id", {5'd0, first_fault_id}, 8'd3);

    // ack on the same edge as the channel 7 rise
    raw_in = 8'hC9;
    step(17);
    ff_ack = 1'b1;
    step(1);
    ff_ack = 1'b0;
    chk("ack_rise_q7", {7'd0, qual_out[7]}, 8'd1);
    chk("ack_rise_id", {5'd0, first_fault_id}, 8'd7);
    chk("ack_rise_v",  {7'd0, first_fault_valid}, 8'd1);
    step(2);
    ff_ack = 1'b1;
    step(1);
    ff_ack = 1'b0;
    chk("lone_ack_v",  {7'd0, first_fault_valid}, 8'd0);
    chk("lone_ack_id", {5'd0, first_fault_id}, 8'd7);

    // reset while 8'h81 qualified and channel 1 mid-count
    raw_in = 8'h00;
    step(70);
    raw_in = 8'h81;
    step(20);
    chk("mid_pre_qual", qual_out, 8'h81);
    raw_in = 8'h83;
    step(5);
    do_reset(1);
    chk("mid_rst_qual", qual_out, 8'h00);
    chk("mid_rst_rise", rise_pulse, 8'h00);
    chk("mid_rst_v",    {7'd0, first_fault_valid}, 8'd0);
    step(17);
    chk("requal_hold", qual_out, 8'h00);
    step(1);
    chk("requal_on", qual_out, 8'h83);

    // random traffic: slow bit flips with occasional glitches, acks and resets
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 29) == 0) raw_in[b] = ~raw_in[b];
      ff_ack = ($urandom_range(0, 15) == 0);
      reset  = ($urandom_range(0, 799) == 0);
      step(1);
    end
    reset  = 1'b0;
    ff_ack = 1'b0;
    step(3);
    if (exp_q.size() > 1) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected at most 1", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rpsc_fault_qualifier.md
# rpsc_fault_qualifier

Input-conditioning stage directly upstream of the RPSC card-12 fault latch block (FF41–FF48). It synchronises eight raw fault and alarm comparator signals and applies asymmetric persistence filtering to each (on-delay and off-delay). The qualified levels drive the card-12 `*_IN` pins. It also reports which channel faulted first since the last acknowledge.

## Interface
Parameters:
- `ON_CYCLES`, default 16: consecutive synchronised-high cycles required to assert a channel; legal range 1..65535.
- `OFF_CYCLES`, default 64: consecutive synchronised-low cycles required to deassert a channel; legal range 1..65535.

Ports:
- `clk`, in, 1: system clock. The block uses only this one clock.
- `reset`, in, 1: synchronous, active-high reset.
- `raw_in`, in, 8: asynchronous comparator outputs. Channel mapping:
  - bit0 U_CA_Low (FF41)
  - bit1 I_CA_High (FF42)
  - bit2 U_G1_Low (FF43)
  - bit3 U_AN_Low (FF44)
  - bit4 I_AN_High (FF45)
  - bit5 U_G2_Low (FF46)
  - bit6 DC_PS_Low (FF47)
  - bit7 Alarm (FF48)
- `ff_ack`, in, 1: single-cycle pulse that clears the first-fault record.
- `qual_out`, out, 8: qualified levels, same bit mapping. These drive card-12 `i*_IN`.
- `rise_pulse`, out, 8: one-cycle pulse on each `qual_out` 0→1 transition.
- `first_fault_id`, out, 3: index of the first channel to qualify high.
- `first_fault_valid`, out, 1: `first_fault_id` holds a captured value.

## Operation
- **Synchroniser.** Each bit passes through a 2-flop synchroniser: `s1 <= raw_in`, `sync <= s1`. Both flops reset to 0.
- **Per-channel filter.** Each channel has a 16-bit counter `cnt` and a state bit `q`, where `q` = `qual_out[i]`.
  - When `q`=0:
    - `sync`=1 and `cnt`=ON_CYCLES-1 → `q`←1, `cnt`←0.
    - `sync`=1 otherwise → `cnt`←`cnt`+1.
    - `sync`=0 → `cnt`←0.
  - When `q`=1:
    - `sync`=0 and `cnt`=OFF_CYCLES-1 → `q`←0, `cnt`←0.
    - `sync`=0 otherwise → `cnt`←`cnt`+1.
    - `sync`=1 → `cnt`←0.
  - Any glitch shorter than the threshold restarts the count. The counter never exceeds threshold-1, so it cannot wrap.
- **Rise pulses.** `rise_pulse[i]` is registered. It is 1 for exactly the cycle in which `qual_out[i]` first reads 1.
- **First-fault capture.** Each edge is evaluated in this order:
  1. If `ff_ack`=1, clear `first_fault_valid`.
  2. If the record is then empty and any channel qualifies high on this edge, capture the lowest-indexed such channel into `first_fault_id` and set `first_fault_valid`=1.
- While `first_fault_valid`=1, later rises do not change `first_fault_id`.
- `ff_ack` while the record is empty is harmless.
- `first_fault_id` holds its last value after it is cleared. Consumers must qualify it with `first_fault_valid`.
- Channels are fully independent. Simultaneous events on several channels are each processed in the same cycle.

## Timing
- **Reset values.** All outputs are 0 on the edge where `reset`=1: `qual_out`, `rise_pulse`, `first_fault_id`, `first_fault_valid`. All counters and synchroniser flops are also 0.
- **Reset mid-count or mid-active.** Every channel drops to 0 on that edge. No `rise_pulse` fires. The first-fault record is cleared. Filtering restarts from zero after reset is released.
- **Assertion latency.** Suppose `raw_in[i]` rises before edge E and stays high.
  - `sync` reads 1 after edge E+1.
  - `qual_out[i]` reads 1 after edge E+1+ON_CYCLES, i.e. after E+17 with the defaults.
  - `rise_pulse[i]` is high during that same cycle.
- **Deassertion latency.** Symmetric: `qual_out[i]` reads 0 after edge E+1+OFF_CYCLES, i.e. after E+65 with the defaults.
- **Minimum thresholds.** With ON_CYCLES=1 the filter adds one cycle; total latency is 2 edges after `raw_in` changes.
- **First-fault timing.** `first_fault_valid` and `first_fault_id` update on the same edge as the corresponding `qual_out` rise.
- **Throughput.** Every channel is evaluated every cycle. There is no back-pressure.

## Test plan
- **Reset values.** Apply reset for 3 cycles with `raw_in`=8'hFF → all outputs 0 during reset. After release, `qual_out`=8'hFF after edge 17 of `raw_in` being held.
- **Glitch rejection.** Defaults; `raw_in[2]` high for 15 cycles, low for 1 cycle, then high → `qual_out[2]` stays 0 until 16 consecutive `sync` highs. `rise_pulse[2]` fires exactly once.
- **Off-delay.** Once `qual_out[5]`=1, drive `raw_in[5]` low for 63 cycles then high → `qual_out[5]` stays 1. After a full 64-cycle low, `qual_out[5]` is 0 on edge E+65.
- **First fault, simultaneous rise.** `raw_in` bits 3 and 6 rise on the same edge → `first_fault_id`=3, `first_fault_valid`=1. A later rise on bit 0 leaves the id at 3.
- **Ack with coincident rise.** Pulse `ff_ack` on the same edge that `qual_out[7]` rises → `first_fault_valid` stays 1 and `first_fault_id`=7. A lone ack afterwards → `first_fault_valid`=0.
- **Reset mid-operation.** Assert reset while `qual_out`=8'h81 and a count is in progress → all outputs 0 next edge. After release with `raw_in` still high, requalification again takes 1+ON_CYCLES edges.
